// File: rtl/riir_pkg.sv
// Shared types and width helpers for the multi-channel cascaded exponential averager.
package riir_pkg;

   localparam int K_W = 5;

   typedef enum logic {IDLE, RUN} state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int acc_w(input int w_data, input int k_max);
      return w_data + k_max + 1;
   endfunction

endpackage

// File: rtl/riir_section_alu.sv
// One first-order section: z' = z + x - (z >>> k), y = z' >>> k (floor shifts).
module riir_section_alu
   import riir_pkg::*;
#(
   parameter int W_DATA = 32,
   parameter int W_ACC  = 58
) (
   input  logic signed [W_ACC-1:0]  z,
   input  logic signed [W_DATA-1:0] x,
   input  logic        [K_W-1:0]    k,
   output logic signed [W_ACC-1:0]  z_next,
   output logic signed [W_DATA-1:0] y
);

   logic signed [W_ACC-1:0] x_ext;
   logic signed [W_ACC-1:0] z_new;

   always_comb begin
      x_ext  = {{(W_ACC-W_DATA){x[W_DATA-1]}}, x};
      z_new  = z + x_ext - (z >>> k);
      z_next = z_new;
      // The section has unity DC gain, so the shifted value always fits W_DATA.
      y      = W_DATA'(z_new >>> k);
   end

endmodule

// File: rtl/riir_mc_cascade.sv
// Time-multiplexed multi-channel cascade of first-order shift-coefficient IIR lowpass sections.
module riir_mc_cascade
   import riir_pkg::*;
#(
   parameter int W_DATA   = 32,
   parameter int CHANNELS = 2,
   parameter int STAGES   = 2,
   parameter int K_OFFSET = 10,
   parameter int K_MAX    = 25
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst_n,
   input  logic signed [W_DATA-1:0]      in_data,
   input  logic [idx_w(CHANNELS)-1:0]    in_chan,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [3:0]                    b,
   input  logic                          clear,
   output logic signed [W_DATA-1:0]      out_data,
   output logic [idx_w(CHANNELS)-1:0]    out_chan,
   output logic                          out_valid
);

   localparam int W_ACC = acc_w(W_DATA, K_MAX);
   localparam int CW    = idx_w(CHANNELS);
   localparam int SW    = idx_w(STAGES);
   localparam int NZ    = CHANNELS * STAGES;
   localparam int ZW    = idx_w(NZ);

   state_t state, state_next;

   logic signed [W_ACC-1:0]  z [NZ];
   logic signed [W_DATA-1:0] x_reg;
   logic [CW-1:0]            ch_reg;
   logic [K_W-1:0]           k_reg;
   logic [K_W-1:0]           k_sel;
   logic [SW-1:0]            s_cnt;
   logic                     accept;
   logic                     last;
   logic                     ch_ok;
   logic [ZW-1:0]            z_idx;
   logic signed [W_ACC-1:0]  z_cur;
   logic signed [W_ACC-1:0]  z_new;
   logic signed [W_DATA-1:0] y;

   always_comb begin
      k_sel = K_W'(K_MAX);
      if (int'(b) + K_OFFSET < K_MAX) k_sel = K_W'(int'(b) + K_OFFSET);
   end

   assign accept = in_valid & in_ready;
   assign last   = (s_cnt == SW'(STAGES - 1));
   assign ch_ok  = (int'(ch_reg) < CHANNELS);
   // Out-of-range channel tags read zero state and never write back.
   assign z_idx  = ch_ok ? ZW'(int'(ch_reg) * STAGES + int'(s_cnt)) : '0;
   assign z_cur  = ch_ok ? z[z_idx] : '0;

   riir_section_alu #(
      .W_DATA (W_DATA),
      .W_ACC  (W_ACC)
   ) u_alu (
      .z      (z_cur),
      .x      (x_reg),
      .k      (k_reg),
      .z_next (z_new),
      .y      (y)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = RUN;
         RUN:     if (last)   state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   always_comb begin
      in_ready = (state == IDLE) && !clear;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         z         <= '{default: '0};
         x_reg     <= '0;
         ch_reg    <= '0;
         k_reg     <= '0;
         s_cnt     <= '0;
         out_data  <= '0;
         out_chan  <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (clear) begin
            z     <= '{default: '0};
            s_cnt <= '0;
         end else if (accept) begin
            x_reg  <= in_data;
            ch_reg <= in_chan;
            k_reg  <= k_sel;
            s_cnt  <= '0;
         end else if (state == RUN) begin
            if (ch_ok) z[z_idx] <= z_new;
            x_reg <= y;
            s_cnt <= s_cnt + SW'(1);
            if (last) begin
               s_cnt <= '0;
               if (ch_ok) begin
                  out_data  <= y;
                  out_chan  <= ch_reg;
                  out_valid <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_riir_mc_cascade.sv
// Scoreboard bench for riir_mc_cascade: three configurations share clock and reset.
module tb_riir_mc_cascade;

   typedef struct {
      int                 dut;
      logic signed [31:0] data;
      logic               chan;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic               iv [3];
   logic               ic [3];
   logic               clr [3];
   logic signed [31:0] id [3];
   logic [3:0]         bsel [3];

   logic               ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
   logic               oc_a, oc_b, oc_c;
   logic signed [31:0] od_a, od_b, od_c;
   logic               ir [3];
   logic               ov [3];
   logic               oc [3];
   logic signed [31:0] od [3];

   always_comb begin
      ir = '{ir_a, ir_b, ir_c};
      ov = '{ov_a, ov_b, ov_c};
      oc = '{oc_a, oc_b, oc_c};
      od = '{od_a, od_b, od_c};
   end

   exp_t   q0[$], q1[$], q2[$];
   int     n_checks = 0;
   int     n_fail = 0;
   longint mz [2][2];
   longint za;

   riir_mc_cascade #(.W_DATA(32), .CHANNELS(1), .STAGES(1), .K_OFFSET(0), .K_MAX(20)) u_a (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(id[0]), .in_chan(ic[0]), .in_valid(iv[0]),
      .in_ready(ir_a), .b(bsel[0]), .clear(clr[0]), .out_data(od_a), .out_chan(oc_a),
      .out_valid(ov_a));

   riir_mc_cascade #(.W_DATA(32), .CHANNELS(2), .STAGES(2), .K_OFFSET(0), .K_MAX(20)) u_b (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(id[1]), .in_chan(ic[1]), .in_valid(iv[1]),
      .in_ready(ir_b), .b(bsel[1]), .clear(clr[1]), .out_data(od_b), .out_chan(oc_b),
      .out_valid(ov_b));

   riir_mc_cascade #(.W_DATA(32), .CHANNELS(1), .STAGES(1), .K_OFFSET(10), .K_MAX(20)) u_c (
      .sys_clk(clk), .sys_rst_n(rst_n), .in_data(id[2]), .in_chan(ic[2]), .in_valid(iv[2]),
      .in_ready(ir_c), .b(bsel[2]), .clear(clr[2]), .out_data(od_c), .out_chan(oc_c),
      .out_valid(ov_c));

   task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] req);
      n_checks++;
      if (got !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", nm, got, req);
      end
   endtask

   task automatic push(input int d, input int data, input int ch);
      exp_t e;
      e.dut  = d;
      e.data = data;
      e.chan = ch[0];
      case (d)
         0:       q0.push_back(e);
         1:       q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   task automatic send(input int d, input int ch, input int x, input int bb);
      int n = 0;
      @(negedge clk);
      while (!ir[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout dut%0d: in_ready stayed 0, required 1", d);
      end
      iv[d]   = 1'b1;
      id[d]   = x;
      ic[d]   = ch[0];
      bsel[d] = bb[3:0];
      @(posedge clk);
      #1 iv[d] = 1'b0;
   endtask

   // Golden models straight from the section recurrence, using 64-bit state.
   function automatic int model_a(input int x, input int k);
      za = za + longint'(x) - (za >>> k);
      return int'(za >>> k);
   endfunction

   function automatic int model_b(input int ch, input int x, input int k);
      longint xs = longint'(x);
      for (int s = 0; s < 2; s++) begin
         mz[ch][s] = mz[ch][s] + xs - (mz[ch][s] >>> k);
         xs = mz[ch][s] >>> k;
      end
      return int'(xs);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      logic have;
      for (int d = 0; d < 3; d++) begin
         if (ov[d] === 1'b1) begin
            have = 1'b0;
            case (d)
               0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
               1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
               default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            n_checks++;
            if (!have) begin
               n_fail++;
               $display("FAIL unexpected_out dut%0d: got data %0d, required no output", d, od[d]);
            end else if (od[d] !== e.data || oc[d] !== e.chan) begin
               n_fail++;
               $display("FAIL out dut%0d: got data %0d chan %0d, required data %0d chan %0d",
                        d, od[d], oc[d], e.data, e.chan);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int lowcnt;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ic[d] = 1'b0; clr[d] = 1'b0; id[d] = '0; bsel[d] = '0;
      end
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 2; s++) mz[c][s] = 0;
      za = 0;

      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         chk("reset_out_valid", ov[d], 0);
         chk("reset_out_data", od[d], 0);
         chk("reset_out_chan", oc[d], 0);
         chk("reset_in_ready", ir[d], 1);
      end
      @(negedge clk) rst_n = 1'b1;

      // Single-section step response, k = 2
      push(0, 250, 0); send(0, 0, 1000, 2);
      push(0, 437, 0); send(0, 0, 1000, 2);
      push(0, 578, 0); send(0, 0, 1000, 2);
      za = 2313;
      for (int i = 0; i < 40; i++) begin
         push(0, model_a(1000, 2), 0);
         send(0, 0, 1000, 2);
      end
      repeat (3) @(negedge clk);
      chk("converged_1000", od[0], 1000);
      chk("idle_out_valid_low", ov[0], 0);

      // Clear while idle blocks acceptance
      @(negedge clk);
      clr[0] = 1'b1; iv[0] = 1'b1; id[0] = 777; bsel[0] = 4'd2;
      #1 chk("ready_during_clear", ir[0], 0);
      @(posedge clk);
      #1 begin clr[0] = 1'b0; iv[0] = 1'b0; end

      // Negative step exposes floor asymmetry
      push(0, -250, 0); send(0, 0, -1000, 2);
      push(0, -438, 0); send(0, 0, -1000, 2);

      // Clear during RUN aborts the sample and zeroes state
      send(0, 0, 1000, 2);
      clr[0] = 1'b1;
      @(posedge clk);
      #1 clr[0] = 1'b0;
      push(0, 250, 0); send(0, 0, 1000, 2);

      // Shift clamp (b=15 -> k=20) and b latched at accept
      push(2, 2, 0);    send(2, 0, 3000000, 15);
      push(2, 5, 0);    send(2, 0, 3000000, 15);
      bsel[2] = 4'd0;
      push(2, 8783, 0); send(2, 0, 3000000, 0);

      // Latency and handshake on the two-stage cascade
      @(negedge clk);
      push(1, model_b(0, 1000, 2), 0);
      iv[1] = 1'b1; id[1] = 1000; ic[1] = 1'b0; bsel[1] = 4'd2;
      @(posedge clk);
      #1 iv[1] = 1'b0;
      lat = 0;
      lowcnt = 0;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (ov[1] === 1'b1) begin
            lat = n;
            break;
         end
         if (ir[1] === 1'b0) lowcnt++;
      end
      chk("latency_edges", lat, 3);
      chk("ready_low_cycles", lowcnt, 2);
      chk("ready_in_out_valid_cycle", ir[1], 1);
      push(1, model_b(1, -500, 2), 1);
      iv[1] = 1'b1; id[1] = -500; ic[1] = 1'b1;
      @(posedge clk);
      #1 iv[1] = 1'b0;
      chk("back_to_back_accepted", ir[1], 0);

      // Interleaved channels must each follow their own history
      for (int i = 0; i < 4; i++) begin
         push(1, model_b(0, 1000, 2), 0);  send(1, 0, 1000, 2);
         push(1, model_b(1, -500, 2), 1);  send(1, 1, -500, 2);
      end

      // Reset mid-run aborts the sample and clears outputs immediately
      send(1, 0, 1000, 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrun_reset_out_valid", ov[1], 0);
      chk("midrun_reset_out_data", od[1], 0);
      chk("midrun_reset_out_chan", oc[1], 0);
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);

      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
